// File: rtl/key_pkg.sv
// Shared types and level constants for the multi-channel key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    HELD       = 2'd2,
    REL_FILT   = 2'd3
  } key_state_e;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, filter FSM, press/release pulses.
// Optional long-press hold counter enabled by macro KEY_LONG_PRESS_EN.
//
// state      | meaning
// IDLE       | released, waiting for a low level
// PRESS_FILT | low seen, counting stable-low cycles
// HELD       | accepted press, waiting for a high level
// REL_FILT   | high seen while held, counting stable-high cycles
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
`ifdef KEY_LONG_PRESS_EN
  , parameter int unsigned LONG_CYCLES = 50000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  key_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             level_q;
  logic             press_q;
  logic             rel_q;
  logic             cnt_done;
  logic             press_accept;
  logic             rel_accept;

  assign sync         = sync_q[1];
  assign cnt_done     = (cnt == CNT_LAST);
  assign press_accept = (state == PRESS_FILT) && (sync == KEY_PRESSED) && cnt_done;
  assign rel_accept   = (state == REL_FILT) && (sync == KEY_RELEASED) && cnt_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {2{KEY_RELEASED}};
      state   <= IDLE;
      cnt     <= '0;
      level_q <= KEY_RELEASED;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_in};
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (sync == KEY_PRESSED) begin
            state <= PRESS_FILT;
            cnt   <= '0;
          end
        end
        PRESS_FILT: begin
          if (sync == KEY_RELEASED) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            state   <= HELD;
            cnt     <= '0;
            level_q <= KEY_PRESSED;
            press_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (sync == KEY_RELEASED) begin
            state <= REL_FILT;
            cnt   <= '0;
          end
        end
        REL_FILT: begin
          if (sync == KEY_PRESSED) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt_done) begin
            state   <= IDLE;
            cnt     <= '0;
            level_q <= KEY_RELEASED;
            rel_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic              long_q;

  // Counter parks at LONG_CYCLES so the pulse fires once per accepted press;
  // a release accepted on the same edge wins so pulses never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_accept) begin
        hold_cnt <= '0;
      end else if (((state == HELD) || (state == REL_FILT)) && (hold_cnt != HOLD_SAT)) begin
        hold_cnt <= hold_cnt + 1'b1;
        long_q   <= (hold_cnt == HOLD_LAST) && !rel_accept;
      end
    end
  end

  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: NUM_KEYS independent key_debounce_chan instances.
// Long-press detection is built only when macro KEY_LONG_PRESS_EN is defined.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  if (NUM_KEYS < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
    $fatal(1, "key_debounce_multi: NUM_KEYS and cycle parameters must be >= 1");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_LONG_PRESS_EN
      , .LONG_CYCLES   (LONG_CYCLES)
`endif
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi: directed tables, corner sequences,
// and random stimulus against a run-length reference model.
module tb_key_debounce_multi;

  localparam int NK = 4;
  localparam int D  = 8;
  localparam int L  = 32;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level, key_press, key_release, key_long;

  int checks = 0;
  int errors = 0;

  key_debounce_multi #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips after D+1 consecutive synchronized samples
  // that differ from it; long press fires L edges after the press edge.
  logic [NK-1:0] hist0, hist1;
  int            run [NK];
  int            age [NK];
  logic [NK-1:0] m_level, m_press, m_rel, m_long;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0   = '1;
      hist1   = '1;
      m_level = '1;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      for (int i = 0; i < NK; i++) begin
        run[i] = 0;
        age[i] = 0;
      end
    end else begin
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      for (int i = 0; i < NK; i++) begin
        logic s;
        bit   was_pressed, releasing;
        s           = hist1[i];
        was_pressed = (m_level[i] == 1'b0);
        releasing   = 1'b0;
        if (was_pressed && age[i] <= L) age[i]++;
        if (s != m_level[i]) run[i]++;
        else run[i] = 0;
        if (run[i] == D + 1) begin
          run[i]     = 0;
          m_level[i] = ~m_level[i];
          if (m_level[i] == 1'b0) begin
            m_press[i] = 1'b1;
            age[i]     = 0;
          end else begin
            m_rel[i]  = 1'b1;
            releasing = 1'b1;
          end
        end
        if (LONG_EN && was_pressed && age[i] == L && !releasing) m_long[i] = 1'b1;
      end
      hist1 = hist0;
      hist0 = key_in;
    end
  end

  always @(negedge clk) begin
    check("model_level", 32'(key_level), 32'(m_level));
    check("model_press", 32'(key_press), 32'(m_press));
    check("model_release", 32'(key_release), 32'(m_rel));
    check("model_long", 32'(key_long), 32'(m_long));
  end

  typedef struct {
    logic [NK-1:0] mask;
    int            low_cycles;
    logic [NK-1:0] exp_press;
    logic [NK-1:0] exp_level;
  } vec_t;

  vec_t          vecs [6];
  logic [NK-1:0] acc_p, acc_r;
  int            remain [NK];

  initial begin
    vecs[0] = '{4'b0001, 20, 4'b0001, 4'b1110};
    vecs[1] = '{4'b0010,  5, 4'b0000, 4'b1111};
    vecs[2] = '{4'b1100, 12, 4'b1100, 4'b0011};
    vecs[3] = '{4'b1000,  8, 4'b0000, 4'b1111};
    vecs[4] = '{4'b1000,  9, 4'b1000, 4'b0111};
    vecs[5] = '{4'b0101,  9, 4'b0101, 4'b1010};

    key_in = '1;
    rst_n  = 1'b0;
    @(negedge clk);
    #1;
    check("reset_level", 32'(key_level), 32'hF);
    check("reset_pulses", 32'({key_press, key_release, key_long}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press/release on key 0 with exact latency
    key_in[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      check("press0_latency", 32'(key_press[0]), 32'(k == 11));
      if (k == 11) check("press0_level", 32'(key_level[0]), 32'h0);
    end
    @(negedge clk);
    key_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      check("release0_latency", 32'(key_release[0]), 32'(k == 11));
    end
    check("release0_level", 32'(key_level[0]), 32'h1);

    // Long hold on key 0
    @(negedge clk);
    key_in[0] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      check("long0", 32'(key_long[0]), 32'(LONG_EN && k == 43));
    end
    @(negedge clk);
    key_in[0] = 1'b1;
    repeat (20) @(negedge clk);

    // Bounce on key 1: 5 low, 2 high, 5 low, high
    acc_p = '0; acc_r = '0;
    key_in[1] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      acc_p |= key_press;
      acc_r |= key_release;
      if (k == 4) key_in[1] = 1'b1;
      if (k == 6) key_in[1] = 1'b0;
      if (k == 11) key_in[1] = 1'b1;
      if (key_level[1] !== 1'b1) acc_r[1] = 1'b1;
    end
    check("bounce_no_pulse", 32'({acc_p, acc_r}), 32'h0);

    // Keys 2 and 3 pressed together
    @(negedge clk);
    key_in[3:2] = 2'b00;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      check("simul_press", 32'(key_press), (k == 11) ? 32'hC : 32'h0);
    end
    @(negedge clk);
    key_in = '1;
    repeat (20) @(negedge clk);

    // Reset during PRESS_FILT on key 1 with key held
    key_in[1] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_level", 32'(key_level), 32'hF);
    check("rst_mid_pulses", 32'({key_press, key_release, key_long}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      check("rst_refilter_press1", 32'(key_press[1]), 32'(k == 11));
    end
    @(negedge clk);
    key_in = '1;
    repeat (20) @(negedge clk);

    // Table-driven press windows
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      key_in = ~vecs[v].mask;
      acc_p = '0;
      repeat (vecs[v].low_cycles) begin
        @(posedge clk); #1;
        acc_p |= key_press;
      end
      @(negedge clk);
      key_in = '1;
      repeat (3) begin
        @(posedge clk); #1;
        acc_p |= key_press;
      end
      check($sformatf("vec%0d_press", v), 32'(acc_p), 32'(vecs[v].exp_press));
      check($sformatf("vec%0d_level", v), 32'(key_level), 32'(vecs[v].exp_level));
      repeat (30) @(negedge clk);
    end

    // Random run lengths per key, checked by the model
    for (int i = 0; i < NK; i++) remain[i] = $urandom_range(14, 1);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NK; i++) begin
        remain[i]--;
        if (remain[i] == 0) begin
          key_in[i] = ~key_in[i];
          remain[i] = $urandom_range(14, 1);
        end
      end
    end
    key_in = '1;
    repeat (40) @(negedge clk);
    check("final_level", 32'(key_level), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 Parameter NUM_KEYS SHALL be: NUM_KEYS, 4, number of independent key channels (>=1).
REQ-002 Parameter DEBOUNCE_CYCLES SHALL be: DEBOUNCE_CYCLES, 1000000, stable-level cycles required to accept a press or release (>=1).
REQ-003 Parameter LONG_CYCLES SHALL be: LONG_CYCLES, 50000000, held-state cycles before the long-press pulse (>=1).
REQ-004 Port clk SHALL be: clk  input  1  clock, all logic on rising edge.
REQ-005 Port rst_n SHALL be: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port key_in SHALL be: key_in  input  NUM_KEYS  raw asynchronous key levels, 0 = pressed.
REQ-007 Port key_level SHALL be: key_level  output  NUM_KEYS  debounced level per channel, 0 = pressed.
REQ-008 Port key_press SHALL be: key_press  output  NUM_KEYS  one-cycle pulse per accepted press.
REQ-009 Port key_release SHALL be: key_release  output  NUM_KEYS  one-cycle pulse per accepted release.
REQ-010 Port key_long SHALL be: key_long  output  NUM_KEYS  one-cycle pulse per long press (see REQ-024).

Function
REQ-011 Each channel SHALL pass key_in through a 2-flop synchronizer reset to 1; the FSM SHALL see only the second flop (sync).
REQ-012 Each channel SHALL run an independent FSM with states IDLE, PRESS_FILT, HELD, REL_FILT and a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-013 IDLE: sync==0 -> PRESS_FILT, cnt<=0; otherwise stay.
REQ-014 PRESS_FILT: sync==1 -> IDLE, cnt<=0 (bounce rejected); else cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt<=0, key_level<=0, key_press pulse; else cnt<=cnt+1.
REQ-015 HELD: sync==1 -> REL_FILT, cnt<=0; otherwise stay.
REQ-016 REL_FILT: sync==0 -> HELD, cnt<=0; else cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0, key_level<=1, key_release pulse; else cnt<=cnt+1.
REQ-017 Latency: key_in falling between edges 0 and 1 and held low SHALL assert key_press in the cycle after edge DEBOUNCE_CYCLES+3; release SHALL be symmetric.
REQ-018 Any low (or high) excursion shorter than DEBOUNCE_CYCLES sync cycles SHALL produce no pulse and no key_level change.
REQ-019 key_press, key_release, key_long SHALL each be high for exactly one cycle per event and never overlap on the same channel.
REQ-020 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same cycle.
REQ-021 The counter SHALL never exceed DEBOUNCE_CYCLES-1; DEBOUNCE_CYCLES==1 SHALL accept after one stable cycle.

Reset
REQ-022 On rst_n low, asynchronously: all FSMs IDLE, counters 0, synchronizers 1, key_level all ones, key_press/key_release/key_long all zeros.
REQ-023 Reset asserted mid-filter or mid-hold SHALL discard the event; a key still held after reset release SHALL be re-filtered from IDLE and produce a fresh key_press.

Configuration
REQ-024 With macro KEY_LONG_PRESS_EN defined: each channel SHALL have a hold counter (width $clog2(LONG_CYCLES+1)) cleared on entry to HELD from PRESS_FILT, incrementing in HELD and REL_FILT, pulsing key_long once when it reaches LONG_CYCLES-1, then saturating; no re-pulse until the next accepted press.
REQ-025 Without KEY_LONG_PRESS_EN: hold counters SHALL be absent and key_long SHALL be tied to all zeros; all other behaviour identical.

Structure
REQ-026 Package key_pkg SHALL hold the FSM state enum (IDLE, PRESS_FILT, HELD, REL_FILT) and the level constants KEY_PRESSED=0, KEY_RELEASED=1.
REQ-027 Per-channel logic SHALL be sub-module key_debounce_chan, instantiated NUM_KEYS times via generate; the top holds no other state.

Verification (NUM_KEYS=4, DEBOUNCE_CYCLES=8, LONG_CYCLES=32)
REQ-028 Clean press on key 0 held 20 cycles -> key_press[0] pulse in the cycle after edge 11, key_level[0]=0; release -> key_release[0] 11 cycles later.
REQ-029 Bounce: key 1 low 5 cycles, high 2, low 5, high -> no pulses, key_level[1] stays 1.
REQ-030 Keys 2 and 3 pressed on the same edge -> key_press=4'b1100 in one cycle.
REQ-031 KEY_LONG_PRESS_EN, key 0 held 60 cycles -> single key_long[0] pulse 32 cycles after key_press[0]; undefined macro -> key_long stays 0.
REQ-032 rst_n pulsed low during PRESS_FILT on key 1 with key held -> outputs reset values immediately; key_press[1] 11 cycles after rst_n rises.
